// File: rtl/bcd_serial_fare_accum.sv
// bcd_serial_fare_accum: packed-BCD fare total accumulated one digit per clock through a shared BCD adder
module bcd_serial_fare_accum #(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  add_valid,
   output logic                  add_ready,
   input  logic [4*DIGITS-1:0]   add_value,
   output logic [4*DIGITS-1:0]   total,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   typedef enum logic [1:0] {IDLE, ADD, FIN} state_t;
   state_t state;
   logic [DIGITS-1:0][3:0] op, work, tot, op_clamp;
   logic [IW-1:0] idx;
   logic carry, c_out;
   logic [3:0] sum;
   bcd_adder u_add (
      .a(work[idx]),
      .b(op[idx]),
      .c_in(carry),
      .sum(sum),
      .c_out(c_out)
   );
   always_comb begin
      op_clamp = add_value;
      for (int i = 0; i < DIGITS; i++)
         op_clamp[i] = add_value[4*i +: 4] > 4'd9 ? 4'd9 : add_value[4*i +: 4];
   end
   assign total     = tot;
   assign add_ready = state == IDLE;
   assign busy      = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state    <= IDLE;
         tot      <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
         idx      <= '0;
         carry    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (add_valid) begin
               op    <= op_clamp;
               work  <= tot;
               idx   <= '0;
               carry <= 1'b0;
               state <= ADD;
            end
            ADD: begin
               work[idx] <= sum;
               carry     <= c_out;
               idx       <= idx + 1'b1;
               if (idx == IW'(DIGITS - 1)) state <= FIN;
            end
            FIN: begin
               tot      <= (carry && SATURATE) ? {DIGITS{4'h9}} : work;
               overflow <= overflow | carry;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

module bcd_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out
);
   logic [4:0] s;
   always_comb begin
      s     = {1'b0, a} + {1'b0, b} + {4'b0, c_in};
      c_out = s > 5'd9;
      sum   = c_out ? 4'(s + 5'd6) : s[3:0];
   end
endmodule

// File: tb/tb_bcd_serial_fare_accum.sv
// tb_bcd_serial_fare_accum: directed vectors against saturating and wrapping instances
module tb_bcd_serial_fare_accum;
   logic clk = 1'b0;
   logic rst = 1'b1, clr = 1'b0, add_valid = 1'b0;
   logic [15:0] add_value = '0;
   logic [15:0] total_s, total_w;
   logic ready_s, ready_w, busy_s, busy_w, done_s, done_w, ovf_s, ovf_w;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   bcd_serial_fare_accum #(.DIGITS(4), .SATURATE(1'b1)) dut (
      .clk(clk), .rst(rst), .clr(clr), .add_valid(add_valid), .add_ready(ready_s),
      .add_value(add_value), .total(total_s), .busy(busy_s), .done(done_s), .overflow(ovf_s)
   );
   bcd_serial_fare_accum #(.DIGITS(4), .SATURATE(1'b0)) dut_w (
      .clk(clk), .rst(rst), .clr(clr), .add_valid(add_valid), .add_ready(ready_w),
      .add_value(add_value), .total(total_w), .busy(busy_w), .done(done_w), .overflow(ovf_w)
   );

   typedef struct {
      bit          clr_first;
      logic [15:0] val;
      logic [15:0] exp_sat;
      logic [15:0] exp_wrap;
      bit          exp_ovf;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // called at a negedge with the DUT idle; returns at the negedge where done is seen
   task automatic do_add(input logic [15:0] v);
      logic [15:0] prev;
      int lat;
      chk("ready_before_add", ready_s, 1);
      prev = total_s;
      add_valid = 1'b1;
      add_value = v;
      @(negedge clk);
      add_valid = 1'b0;
      add_value = 16'h5a5a;
      lat = 0;
      while (!done_s && lat < 20) begin
         chk("busy_in_add", busy_s, 1);
         chk("ready_in_add", ready_s, 0);
         chk("total_stable_in_add", total_s, prev);
         @(negedge clk);
         lat++;
      end
      chk("done_latency", lat, 5);
      chk("done_wrap", done_w, 1);
      chk("busy_at_done", busy_s, 0);
      chk("ready_at_done", ready_s, 1);
   endtask

   initial begin
      vecs[0] = '{1'b1, 16'h0007, 16'h0007, 16'h0007, 1'b0};
      vecs[1] = '{1'b0, 16'h0095, 16'h0102, 16'h0102, 1'b0};
      vecs[2] = '{1'b1, 16'h0999, 16'h0999, 16'h0999, 1'b0};
      vecs[3] = '{1'b0, 16'h0001, 16'h1000, 16'h1000, 1'b0};
      vecs[4] = '{1'b1, 16'h9990, 16'h9990, 16'h9990, 1'b0};
      vecs[5] = '{1'b0, 16'h0020, 16'h9999, 16'h0010, 1'b1};
      vecs[6] = '{1'b0, 16'h0001, 16'h9999, 16'h0011, 1'b1};
      vecs[7] = '{1'b1, 16'h00AF, 16'h0099, 16'h0099, 1'b0};
      vecs[8] = '{1'b0, 16'h1234, 16'h1333, 16'h1333, 1'b0};
      vecs[9] = '{1'b0, 16'hFFFF, 16'h9999, 16'h1332, 1'b1};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_total", total_s, 16'h0000);
      chk("rst_total_wrap", total_w, 16'h0000);
      chk("rst_overflow", ovf_s, 0);
      chk("rst_busy", busy_s, 0);
      chk("rst_done", done_s, 0);
      chk("rst_ready", ready_s, 1);
      chk("rst_ready_wrap", ready_w, 1);

      for (int i = 0; i < 10; i++) begin
         if (vecs[i].clr_first) pulse_clr();
         do_add(vecs[i].val);
         chk($sformatf("vec%0d_total_sat", i), total_s, vecs[i].exp_sat);
         chk($sformatf("vec%0d_total_wrap", i), total_w, vecs[i].exp_wrap);
         chk($sformatf("vec%0d_ovf_sat", i), ovf_s, vecs[i].exp_ovf);
         chk($sformatf("vec%0d_ovf_wrap", i), ovf_w, vecs[i].exp_ovf);
         @(negedge clk);
         chk($sformatf("vec%0d_done_one_cycle", i), done_s, 0);
      end

      pulse_clr();
      chk("clr_ovf_sat", ovf_s, 0);
      chk("clr_ovf_wrap", ovf_w, 0);
      chk("clr_total_sat", total_s, 16'h0000);
      chk("clr_total_wrap", total_w, 16'h0000);

      do_add(16'h0123);
      @(negedge clk);
      add_valid = 1'b1;
      add_value = 16'h0050;
      @(negedge clk);
      add_valid = 1'b0;
      chk("abort_busy_add1", busy_s, 1);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("abort_ready", ready_s, 1);
      chk("abort_busy", busy_s, 0);
      chk("abort_total", total_s, 16'h0000);
      chk("abort_ovf", ovf_s, 0);
      for (int c = 0; c < 6; c++) begin
         chk("abort_no_done", done_s, 0);
         @(negedge clk);
      end
      chk("abort_total_after", total_s, 16'h0000);

      do_add(16'h0042);
      @(negedge clk);
      chk("pre_clr_total", total_s, 16'h0042);
      clr = 1'b1;
      add_valid = 1'b1;
      add_value = 16'h0005;
      @(negedge clk);
      clr = 1'b0;
      add_valid = 1'b0;
      chk("clr_wins_busy", busy_s, 0);
      chk("clr_wins_ready", ready_s, 1);
      chk("clr_wins_total", total_s, 16'h0000);
      repeat (7) @(negedge clk);
      chk("clr_wins_no_add", total_s, 16'h0000);

      add_valid = 1'b1;
      add_value = 16'h000C;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 6 || c == 12) begin
            chk($sformatf("b2b_done_c%0d", c), done_s, 1);
            chk($sformatf("b2b_ready_c%0d", c), ready_s, 1);
            chk($sformatf("b2b_total_c%0d", c), total_s, c == 6 ? 16'h0009 : 16'h0018);
         end else begin
            chk($sformatf("b2b_ready_c%0d", c), ready_s, 0);
            chk($sformatf("b2b_busy_c%0d", c), busy_s, 1);
            chk($sformatf("b2b_done_c%0d", c), done_s, 0);
         end
      end
      add_valid = 1'b0;
      repeat (8) @(negedge clk);
      chk("b2b_final_total", total_s, 16'h0018);
      chk("b2b_final_ready", ready_s, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
